// File: rtl/line_buffer_window_gen.sv
// Streaming KX x KY sliding-window generator with line buffers, stride, channels and frame sync.
// Optional macro LBUF_WIN_POS_EN adds registered top-left window coordinates o_win_x / o_win_y.
module line_buffer_window_gen #(
  parameter int unsigned I_F_BW = 8,
  parameter int unsigned CH     = 1,
  parameter int unsigned IX     = 28,
  parameter int unsigned IY     = 28,
  parameter int unsigned KX     = 5,
  parameter int unsigned KY     = 5,
  parameter int unsigned SX     = 1,
  parameter int unsigned SY     = 1,
  localparam int unsigned XW    = (IX > 1) ? $clog2(IX) : 1,
  localparam int unsigned YW    = (IY > 1) ? $clog2(IY) : 1,
  localparam int unsigned PW    = CH * I_F_BW,
  localparam int unsigned WW    = KX * KY * PW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic          i_in_sof,
  input  logic [PW-1:0] i_in_pixel,
  output logic          o_window_valid,
  input  logic          i_window_ready,
  output logic [WW-1:0] o_window,
  output logic          o_frame_done
`ifdef LBUF_WIN_POS_EN
  ,
  output logic [XW-1:0] o_win_x,
  output logic [YW-1:0] o_win_y
`endif
);

  localparam int unsigned NL = (KY > 1) ? KY - 1 : 1;
  localparam int unsigned SW = (KX > 1) ? KX - 1 : 1;

  logic [XW-1:0] x_q, cur_x;
  logic [YW-1:0] y_q, cur_y;
  logic          accept, qual, last_x, last_y;
  logic [PW-1:0] line_mem [NL][IX];
  logic [PW-1:0] col [KY];
  logic [PW-1:0] sr_q [KY][SW];
  logic [WW-1:0] win_d, win_q;
  logic          win_valid_q, done_q;

  assign o_in_ready     = !win_valid_q || i_window_ready;
  assign accept         = i_in_valid && o_in_ready;
  // An SOF pixel is treated as (0,0) regardless of where the counters are.
  assign cur_x          = i_in_sof ? '0 : x_q;
  assign cur_y          = i_in_sof ? '0 : y_q;
  assign last_x         = (32'(cur_x) == IX - 1);
  assign last_y         = (32'(cur_y) == IY - 1);
  assign o_window_valid = win_valid_q;
  assign o_window       = win_q;
  assign o_frame_done   = done_q;

  always_comb begin
    qual = 1'b0;
    if (32'(cur_x) >= KX - 1 && 32'(cur_y) >= KY - 1) begin
      qual = ((32'(cur_x) - (KX - 1)) % SX == 0) && ((32'(cur_y) - (KY - 1)) % SY == 0);
    end
  end

  // line_mem[k] holds line y-1-k; col[KY-1] is the incoming pixel (bottom row).
  always_comb begin
    for (int wy = 0; wy < int'(KY) - 1; wy++) begin
      col[wy] = line_mem[int'(KY) - 2 - wy][cur_x];
    end
    col[KY-1] = i_in_pixel;
  end

  always_comb begin
    win_d = '0;
    for (int wy = 0; wy < int'(KY); wy++) begin
      for (int wx = 0; wx < int'(KX) - 1; wx++) begin
        win_d[(wy * KX + wx) * PW +: PW] = sr_q[wy][wx];
      end
      win_d[(wy * KX + KX - 1) * PW +: PW] = col[wy];
    end
  end

  // Datapath storage is not reset; qualification keeps stale content out of o_window.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_mem[0][cur_x] <= i_in_pixel;
      for (int k = 1; k < int'(NL); k++) begin
        line_mem[k][cur_x] <= line_mem[k-1][cur_x];
      end
      for (int wy = 0; wy < int'(KY); wy++) begin
        for (int j = 0; j < int'(SW) - 1; j++) begin
          sr_q[wy][j] <= sr_q[wy][j+1];
        end
        sr_q[wy][SW-1] <= col[wy];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      win_valid_q <= 1'b0;
      win_q       <= '0;
      done_q      <= 1'b0;
`ifdef LBUF_WIN_POS_EN
      o_win_x     <= '0;
      o_win_y     <= '0;
`endif
    end else begin
      done_q <= accept && last_x && last_y;
      if (accept) begin
        x_q <= last_x ? '0 : cur_x + XW'(1);
        y_q <= last_x ? (last_y ? '0 : cur_y + YW'(1)) : cur_y;
      end
      if (accept && qual) begin
        win_valid_q <= 1'b1;
        win_q       <= win_d;
`ifdef LBUF_WIN_POS_EN
        o_win_x     <= cur_x - XW'(KX - 1);
        o_win_y     <= cur_y - YW'(KY - 1);
`endif
      end else if (i_window_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_window_gen.sv
// Randomized self-checking bench for line_buffer_window_gen against a frame-array window model.
module tb_line_buffer_window_gen;

  localparam int BW = 8;
  localparam int CH = 2;
  localparam int IX = 8;
  localparam int IY = 7;
  localparam int KX = 3;
  localparam int KY = 2;
  localparam int SX = 2;
  localparam int SY = 2;
  localparam int PW = CH * BW;
  localparam int WW = KX * KY * PW;
  localparam int NWIN = ((IX - KX) / SX + 1) * ((IY - KY) / SY + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic          win_ready = 1'b0;
  logic          in_ready, win_valid, frame_done;
  logic [WW-1:0] window;
`ifdef LBUF_WIN_POS_EN
  logic [2:0]    win_x, win_y;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [PW-1:0] pix [IY][IX];
  logic [WW-1:0] got_win [$];
  int            got_x [$];
  int            got_y [$];

  line_buffer_window_gen #(
    .I_F_BW(BW), .CH(CH), .IX(IX), .IY(IY), .KX(KX), .KY(KY), .SX(SX), .SY(SY)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_sof      (in_sof),
    .i_in_pixel    (in_pixel),
    .o_window_valid(win_valid),
    .i_window_ready(win_ready),
    .o_window      (window),
    .o_frame_done  (frame_done)
`ifdef LBUF_WIN_POS_EN
    ,
    .o_win_x       (win_x),
    .o_win_y       (win_y)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit qual(input int x, input int y);
    return x >= KX - 1 && y >= KY - 1 && (x - KX + 1) % SX == 0 && (y - KY + 1) % SY == 0;
  endfunction

  function automatic logic [WW-1:0] exp_win(input int x, input int y);
    logic [WW-1:0] w;
    logic [PW-1:0] p;
    w = '0;
    for (int wy = 0; wy < KY; wy++) begin
      for (int wx = 0; wx < KX; wx++) begin
        p = pix[y - KY + 1 + wy][x - KX + 1 + wx];
        for (int c = 0; c < CH; c++) w[((wy * KX + wx) * CH + c) * BW +: BW] = p[c * BW +: BW];
      end
    end
    return w;
  endfunction

  task automatic fill_frame();
    for (int y = 0; y < IY; y++)
      for (int x = 0; x < IX; x++) pix[y][x] = PW'($urandom);
  endtask

  // Streams pixels [first, first+npix) of pix with random gaps and random downstream ready,
  // collecting consumed windows; returns protocol-violation tallies for the caller to judge.
  task automatic run_pixels(input int first, input int npix, input bit sof_first,
                            input int ready_pct, output int ndone, output int nhold_bad,
                            output int nrdy_bad, output bit ok_end);
    int            k, cyc;
    logic          prev_hold;
    logic [WW-1:0] prev_w;
    k = first; cyc = 0; prev_hold = 1'b0; prev_w = '0;
    ndone = 0; nhold_bad = 0; nrdy_bad = 0;
    got_win.delete(); got_x.delete(); got_y.delete();
    while ((k < first + npix || win_valid) && cyc < 4000) begin
      if (prev_hold && (!win_valid || window !== prev_w)) nhold_bad++;
      in_valid  = (k < first + npix) && ($urandom_range(99) < 80);
      in_pixel  = in_valid ? pix[k / IX][k % IX] : PW'($urandom);
      in_sof    = sof_first && (k == first);
      win_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (in_ready !== (!win_valid || win_ready)) nrdy_bad++;
      if (win_valid && win_ready) begin
        got_win.push_back(window);
`ifdef LBUF_WIN_POS_EN
        got_x.push_back(int'(win_x));
        got_y.push_back(int'(win_y));
`endif
      end
      if (in_valid && in_ready) k++;
      prev_hold = win_valid && !win_ready;
      prev_w    = window;
      @(posedge clk); #1;
      if (frame_done) ndone++;
      cyc++;
    end
    in_valid = 1'b0; in_sof = 1'b0; win_ready = 1'b0;
    ok_end = (k == first + npix) && !win_valid;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (win_valid !== 1'b0 || window !== '0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b window=%h done=%b required 0/0/0",
               win_valid, window, frame_done);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  // Continuous stream, ready held high: checks 1-cycle latency, every window, frame_done timing.
  task automatic test_stream();
    int nw;
    for (int f = 0; f < 2; f++) begin
      fill_frame();
      nw = 0;
      for (int k = 0; k < IX * IY; k++) begin
        in_valid = 1'b1; in_sof = 1'b0; win_ready = 1'b1; in_pixel = pix[k / IX][k % IX];
        @(posedge clk); #1;
        n_tests++;
        if (win_valid !== qual(k % IX, k / IX)) begin
          n_fail++;
          $display("FAIL stream_valid f%0d k%0d: valid=%b required %b", f, k, win_valid,
                   qual(k % IX, k / IX));
        end
        if (qual(k % IX, k / IX)) begin
          nw++;
          n_tests++;
          if (window !== exp_win(k % IX, k / IX)) begin
            n_fail++;
            $display("FAIL stream_window f%0d k%0d: got %h required %h", f, k, window,
                     exp_win(k % IX, k / IX));
          end
`ifdef LBUF_WIN_POS_EN
          n_tests++;
          if (int'(win_x) != k % IX - KX + 1 || int'(win_y) != k / IX - KY + 1) begin
            n_fail++;
            $display("FAIL stream_pos k%0d: got (%0d,%0d) required (%0d,%0d)", k, win_x, win_y,
                     k % IX - KX + 1, k / IX - KY + 1);
          end
`endif
        end
        n_tests++;
        if (frame_done !== (k == IX * IY - 1)) begin
          n_fail++;
          $display("FAIL stream_frame_done k%0d: got %b required %b", k, frame_done,
                   k == IX * IY - 1);
        end
      end
      n_tests++;
      if (nw != NWIN) begin
        n_fail++;
        $display("FAIL stream_count f%0d: got %0d required %0d", f, nw, NWIN);
      end
    end
    in_valid = 1'b0; win_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full frame under random backpressure: order, completeness, hold stability, ready rule.
  task automatic test_back_pressure(input int ready_pct);
    int ndone, nhold, nrdy, idx;
    bit ok;
    logic [WW-1:0] exp_q [$];
    int            ex_q [$];
    int            ey_q [$];
    fill_frame();
    for (int k = 0; k < IX * IY; k++) begin
      if (qual(k % IX, k / IX)) begin
        exp_q.push_back(exp_win(k % IX, k / IX));
        ex_q.push_back(k % IX - KX + 1);
        ey_q.push_back(k / IX - KY + 1);
      end
    end
    run_pixels(0, IX * IY, 1'b0, ready_pct, ndone, nhold, nrdy, ok);
    n_tests++;
    if (!ok || got_win.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL bp%0d_count: got %0d windows (end ok=%b) required %0d", ready_pct,
               got_win.size(), ok, exp_q.size());
    end
    idx = (got_win.size() < exp_q.size()) ? got_win.size() : exp_q.size();
    for (int i = 0; i < idx; i++) begin
      n_tests++;
      if (got_win[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp%0d_window %0d: got %h required %h", ready_pct, i, got_win[i], exp_q[i]);
      end
`ifdef LBUF_WIN_POS_EN
      n_tests++;
      if (got_x[i] != ex_q[i] || got_y[i] != ey_q[i]) begin
        n_fail++;
        $display("FAIL bp%0d_pos %0d: got (%0d,%0d) required (%0d,%0d)", ready_pct, i,
                 got_x[i], got_y[i], ex_q[i], ey_q[i]);
      end
`endif
    end
    n_tests++;
    if (ndone != 1 || nhold != 0 || nrdy != 0) begin
      n_fail++;
      $display("FAIL bp%0d_protocol: done=%0d hold_err=%0d ready_err=%0d required 1/0/0",
               ready_pct, ndone, nhold, nrdy);
    end
  endtask

  // Abandon a frame at (4,3) with an SOF; the new frame must yield exactly its own windows.
  task automatic test_sof();
    int ndone, nhold, nrdy, nexp, idx;
    bit ok;
    logic [WW-1:0] exp_q [$];
    fill_frame();
    nexp = 0;
    for (int k = 0; k < 3 * IX + 4; k++) if (qual(k % IX, k / IX)) nexp++;
    run_pixels(0, 3 * IX + 4, 1'b0, 70, ndone, nhold, nrdy, ok);
    n_tests++;
    if (!ok || got_win.size() != nexp || ndone != 0) begin
      n_fail++;
      $display("FAIL sof_partial: got %0d windows done=%0d required %0d windows done=0",
               got_win.size(), ndone, nexp);
    end
    fill_frame();
    for (int k = 0; k < IX * IY; k++) if (qual(k % IX, k / IX)) exp_q.push_back(exp_win(k % IX, k / IX));
    run_pixels(0, IX * IY, 1'b1, 70, ndone, nhold, nrdy, ok);
    n_tests++;
    if (!ok || got_win.size() != NWIN || ndone != 1) begin
      n_fail++;
      $display("FAIL sof_frame: got %0d windows done=%0d required %0d windows done=1",
               got_win.size(), ndone, NWIN);
    end
    idx = (got_win.size() < exp_q.size()) ? got_win.size() : exp_q.size();
    for (int i = 0; i < idx; i++) begin
      n_tests++;
      if (got_win[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL sof_window %0d: got %h required %h", i, got_win[i], exp_q[i]);
      end
    end
  endtask

  // Reset while a window is held, then a full frame without SOF.
  task automatic test_reset_mid();
    int  k, ndone, nhold, nrdy, idx;
    bit  ok, acc;
    logic [WW-1:0] exp_q [$];
    fill_frame();
    k = 0;
    win_ready = 1'b0;
    for (int c = 0; c < IX * IY && !win_valid; c++) begin
      in_valid = 1'b1; in_pixel = pix[k / IX][k % IX];
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    n_tests++;
    if (win_valid !== 1'b1 || window !== exp_win(KX - 1, KY - 1)) begin
      n_fail++;
      $display("FAIL rstmid_first: valid=%b got %h required 1/%h", win_valid, window,
               exp_win(KX - 1, KY - 1));
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clk); #1;
    reset_n  = 1'b1;
    n_tests++;
    if (win_valid !== 1'b0 || window !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_state: valid=%b window=%h ready=%b required 0/0/1", win_valid,
               window, in_ready);
    end
    fill_frame();
    for (int j = 0; j < IX * IY; j++) if (qual(j % IX, j / IX)) exp_q.push_back(exp_win(j % IX, j / IX));
    run_pixels(0, IX * IY, 1'b0, 60, ndone, nhold, nrdy, ok);
    n_tests++;
    if (!ok || got_win.size() != NWIN || ndone != 1) begin
      n_fail++;
      $display("FAIL rstmid_frame: got %0d windows done=%0d required %0d windows done=1",
               got_win.size(), ndone, NWIN);
    end
    idx = (got_win.size() < exp_q.size()) ? got_win.size() : exp_q.size();
    for (int i = 0; i < idx; i++) begin
      n_tests++;
      if (got_win[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rstmid_window %0d: got %h required %h", i, got_win[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure(50);
    test_back_pressure(20);
    test_sof();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
